mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates one unified single-port memory between the IF stage (instruction fetch) and the MEM stage (LD/ST driven by MEM_R_EN/MEM_W_EN from the controller). Data accesses have priority over fetches. Transactions are never preempted. Each transaction completes with a one-cycle response pulse. While a stage's access is outstanding, the arbiter drives that stage's stall/freeze. A watchdog aborts memory transactions that hang.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
if_req  in  1  IF stage wants an instruction
if_addr  in  ADDR_W  fetch address (PC)
if_ready  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction, held until next if_ready
if_stall  out  1  freeze PC / IF-ID register
dm_rd_en  in  1  MEM-stage load (MEM_R_EN)
dm_wr_en  in  1  MEM-stage store (MEM_W_EN)
dm_addr  in  ADDR_W  data address (ALU result)
dm_wdata  in  DATA_W  store data
dm_ready  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data, held until next dm_ready
pipe_freeze  out  1  freeze all pipeline registers
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write when 1
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  memory completes request this cycle; mem_rdata valid
mem_rdata  in  DATA_W  read data
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=0): state IDLE. mem_req, mem_we, if_ready, dm_ready and err_timeout are 0. mem_addr, mem_wdata, if_rdata and dm_rdata are 0. Watchdog count is 0. Reset mid-transaction drops mem_req immediately and issues no response.
- States: IDLE, D_BUSY, I_BUSY, D_RESP, I_RESP.
- IDLE:
  - If dm_rd_en|dm_wr_en: go to D_BUSY and register mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_wr_en, mem_req=1.
  - Else if if_req: go to I_BUSY and register mem_addr=if_addr, mem_we=0, mem_req=1.
  - Else stay in IDLE.
- Both dm_rd_en and dm_wr_en high: treated as a store.
- D_BUSY / I_BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack: mem_req<=0. Latch mem_rdata into dm_rdata (loads only; stores leave dm_rdata unchanged) or into if_rdata. Go to D_RESP / I_RESP.
- D_RESP / I_RESP: dm_ready / if_ready =1 for exactly this cycle, then go to IDLE. No new request is issued from a RESP state. This blocks re-issue of the request the pipeline is still presenting during its advancing edge.
- Latency: request seen in IDLE at cycle t gives mem_req=1 from t+1. mem_ack at cycle a gives ready at a+1 and IDLE at a+2. Minimum is 2 cycles request-to-ready. Back-to-back transactions are separated by one IDLE cycle.
- pipe_freeze (combinational) = (dm_rd_en|dm_wr_en) & ~dm_ready.
- if_stall (combinational) = pipe_freeze | (if_req & ~if_ready).
- Consequence: a fetch completing while pipe_freeze=1 is lost. IF re-requests the same PC and the arbiter fetches again. This is functionally correct.
- Priority: if both requests are present in IDLE, data wins. IF waits until the data response plus the IDLE cycle.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ack=0. Clears on every issue.
  - When count reaches TIMEOUT_CYCLES: mem_req<=0, err_timeout<=1 (sticky until reset). The returned rdata is 0 and the matching RESP state is entered normally, so the pipeline never deadlocks.
- mem_ack while not in a BUSY state is ignored.

Decomposition:
- Package mem_arb_pkg: state enum (5 states, 3-bit encoding) and default ADDR_W/DATA_W constants, shared with the controller defines.
- Sub-module mem_arb_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset then if_req=1, if_addr=0x40, mem_ack one cycle after mem_req rises with mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_we=0; if_ready pulses 1 cycle with if_rdata=0xDEADBEEF; if_stall low in that cycle.
- dm_rd_en=1 and if_req=1 together, addr 0x100 / 0x44 -> data issued first (mem_addr=0x100). pipe_freeze stays high until dm_ready. Fetch of 0x44 issues 2 cycles after the data mem_ack.
- Store dm_wr_en=1, dm_addr=0x200, dm_wdata=0x12345678, ack after 3 cycles -> mem_we=1 with stable addr/data for 3 cycles; dm_ready pulse; dm_rdata unchanged; no re-issue in the dm_ready cycle.
- mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles; err_timeout=1 and stays; ready pulses with rdata=0.
- rst low during D_BUSY -> mem_req=0 asynchronously; no dm_ready; after release with dm_rd_en still high, the access re-issues from IDLE.
- Sustained if_req with mem_ack in the first request cycle -> one fetch every 3 cycles; an if_ready pulse occurs each time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and default bus widths.
// No logic, no latency, no flow control of its own.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_BUSY = 3'd1,
        ST_I_BUSY = 3'd2,
        ST_D_RESP = 3'd3,
        ST_I_RESP = 3'd4
    } arb_state_t;

    function automatic logic is_busy(arb_state_t s);
        return (s == ST_D_BUSY) || (s == ST_I_BUSY);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts enabled cycles; expired is combinational on the cycle the count would hit TIMEOUT_CYCLES.
// Latency 0 to expired; clr has priority over en; no backpressure.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th waiting cycle so the owner can drop the request on that edge.
    assign expired = en && (count == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages; data wins, no preemption, watchdog abort.
// Latency: request->mem_req 1 cycle, mem_ack->ready 1 cycle; stages are stalled via if_stall/pipe_freeze.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              pipe_freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_timeout
);

    arb_state_t state;
    logic       dm_req;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_expired;

    assign dm_req = dm_rd_en | dm_wr_en;
    assign wd_clr = !is_busy(state);
    assign wd_en  = is_busy(state) && mem_req && !mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A store wins when both enables are high.
                    if (dm_req) begin
                        state     <= ST_D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_wr_en;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state    <= ST_I_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        dm_ready <= 1'b1;
                        state    <= ST_D_RESP;
                        if (!mem_we) dm_rdata <= mem_rdata;
                    end else if (wd_expired) begin
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        dm_ready    <= 1'b1;
                        state       <= ST_D_RESP;
                        if (!mem_we) dm_rdata <= '0;
                    end
                end
                ST_I_BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                        state    <= ST_I_RESP;
                    end else if (wd_expired) begin
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        if_ready    <= 1'b1;
                        if_rdata    <= '0;
                        state       <= ST_I_RESP;
                    end
                end
                // The stage still presents its old request on this edge, so never issue from here.
                ST_D_RESP, ST_I_RESP: state <= ST_IDLE;
                default:              state <= ST_IDLE;
            endcase
        end
    end

    assign pipe_freeze = dm_req & ~dm_ready;
    assign if_stall    = pipe_freeze | (if_req & ~if_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue-based scoreboard and a scripted memory responder.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_rd_en;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        pipe_freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .if_stall    (if_stall),
        .dm_rd_en    (dm_rd_en),
        .dm_wr_en    (dm_wr_en),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ready    (dm_ready),
        .dm_rdata    (dm_rdata),
        .pipe_freeze (pipe_freeze),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          cwd;
    } iss_t;

    typedef struct {
        bit          data;
        logic [31:0] rdata;
    } rsp_t;

    iss_t        iss_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int last_issue_cyc = 0;
    int ack_delay = 0;
    bit never_ack = 0;
    int wait_cnt = 0;
    logic mon_prev = 1'b0;
    iss_t mon_e;
    rsp_t mon_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_iss(input logic [31:0] a, input logic we, input logic [31:0] wd, input bit cwd);
        iss_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.cwd = cwd;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input bit data, input logic [31:0] rd);
        rsp_t r;
        r.data = data; r.rdata = rd;
        rsp_q.push_back(r);
    endtask

    // Memory model: acks ack_delay cycles after mem_req is first seen, returning the next rd_q word.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !never_ack) begin
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: checks every new memory issue and every ready pulse against the expectation queues.
    initial forever begin
        @(negedge clk);
        if (mem_ack) last_ack_cyc = cyc;
        if (mem_req && !mon_prev) begin
            last_issue_cyc = cyc;
            if (iss_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_issue: addr %h we %b, expected no issue", mem_addr, mem_we);
            end else begin
                mon_e = iss_q.pop_front();
                chk("issue_addr", mem_addr, mon_e.addr);
                chk("issue_we", 32'(mem_we), 32'(mon_e.we));
                if (mon_e.cwd) chk("issue_wdata", mem_wdata, mon_e.wdata);
            end
        end
        mon_prev = mem_req;
        if (if_ready || dm_ready) begin
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: if_ready %b dm_ready %b, expected none", if_ready, dm_ready);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_is_data", 32'(dm_ready), 32'(mon_r.data));
                chk("rsp_rdata", mon_r.data ? dm_rdata : if_rdata, mon_r.rdata);
            end
        end
    end

    // Waits for the ready pulse of the held request, checking stall/freeze and request stability each cycle.
    task automatic wait_rdy(input bit data, input logic [31:0] ea, input logic ewe,
                            input logic [31:0] ewd, input bit cwd, output int reqc);
        int n;
        bit rdy;
        reqc = 0;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 60) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                reqc++;
                chk("hold_addr", mem_addr, ea);
                chk("hold_we", 32'(mem_we), 32'(ewe));
                if (cwd) chk("hold_wdata", mem_wdata, ewd);
            end
            rdy = data ? dm_ready : if_ready;
            if (!rdy)      chk("stall_while_waiting", 32'(if_stall), 32'd1);
            else if (data) chk("freeze_released", 32'(pipe_freeze), 32'd0);
            else           chk("if_stall_released", 32'(if_stall), 32'd0);
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL ready_timeout: no ready within 60 cycles, expected a pulse");
        end
    endtask

    // The pipeline advances on the edge that ends the ready cycle.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    int reqc;
    int t0;
    int a0;
    int n;
    int rc[3];

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_rd_en = 1'b0; dm_wr_en = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, ack in the first request cycle.
        push_iss(32'h40, 1'b0, 32'h0, 1'b0);
        push_rsp(1'b0, 32'hDEADBEEF);
        rd_q.push_back(32'hDEADBEEF);
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h40;
        t0 = cyc;
        wait_rdy(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, reqc);
        chk("t1_req_latency", 32'(last_issue_cyc - t0), 32'd1);
        chk("t1_ready_latency", 32'(cyc - t0), 32'd2);
        chk("t1_ack_to_ready", 32'(cyc - last_ack_cyc), 32'd1);
        chk("t1_req_cycles", 32'(reqc), 32'd1);
        advance();
        if_req = 1'b0;

        // Load and fetch together: data first, fetch issued from the IDLE cycle after dm_ready.
        push_iss(32'h100, 1'b0, 32'h0, 1'b0);
        push_iss(32'h44, 1'b0, 32'h0, 1'b0);
        push_rsp(1'b1, 32'h11110100);
        push_rsp(1'b0, 32'h22220044);
        rd_q.push_back(32'h11110100);
        rd_q.push_back(32'h22220044);
        dm_rd_en = 1'b1; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        wait_rdy(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, reqc);
        a0 = last_ack_cyc;
        advance();
        dm_rd_en = 1'b0;
        wait_rdy(1'b0, 32'h44, 1'b0, 32'h0, 1'b0, reqc);
        chk("t2_fetch_mem_req_after_ack", 32'(last_issue_cyc - a0), 32'd3);
        advance();
        if_req = 1'b0;

        // Store (both enables high), ack on the third request cycle; dm_rdata must keep the load value.
        push_iss(32'h200, 1'b1, 32'h12345678, 1'b1);
        push_rsp(1'b1, 32'h11110100);
        rd_q.push_back(32'hBAD0BAD0);
        ack_delay = 2;
        dm_rd_en = 1'b1; dm_wr_en = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        wait_rdy(1'b1, 32'h200, 1'b1, 32'h12345678, 1'b1, reqc);
        chk("t3_req_cycles", 32'(reqc), 32'd3);
        advance();
        dm_rd_en = 1'b0; dm_wr_en = 1'b0;
        @(negedge clk);
        chk("t3_no_reissue", 32'(mem_req), 32'd0);

        // Watchdog: no ack, request must drop after 16 cycles with zero load data.
        chk("t4_err_before", 32'(err_timeout), 32'd0);
        never_ack = 1'b1;
        push_iss(32'h300, 1'b0, 32'h0, 1'b0);
        push_rsp(1'b1, 32'h0);
        dm_rd_en = 1'b1; dm_addr = 32'h300;
        wait_rdy(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, reqc);
        chk("t4_req_cycles", 32'(reqc), 32'd16);
        chk("t4_err_set", 32'(err_timeout), 32'd1);
        advance();
        dm_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 32'(err_timeout), 32'd1);

        // Asynchronous reset in D_BUSY, then re-issue of the still-present load.
        ack_delay = 1;
        push_iss(32'h400, 1'b0, 32'h0, 1'b0);
        dm_rd_en = 1'b1; dm_addr = 32'h400;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t5_issued", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_mem_req", 32'(mem_req), 32'd0);
        chk("t5_async_mem_addr", mem_addr, 32'h0);
        chk("t5_async_if_rdata", if_rdata, 32'h0);
        chk("t5_async_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        chk("t5_no_dm_ready", 32'(dm_ready), 32'd0);
        push_iss(32'h400, 1'b0, 32'h0, 1'b0);
        push_rsp(1'b1, 32'h44444444);
        rd_q.push_back(32'h44444444);
        never_ack = 1'b0;
        rst = 1'b1;
        wait_rdy(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, reqc);
        chk("t5_req_cycles", 32'(reqc), 32'd2);
        advance();
        dm_rd_en = 1'b0;

        // Sustained fetch stream: one fetch every 3 cycles, PC advancing on each ready.
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            push_iss(32'h80 + 32'(4 * i), 1'b0, 32'h0, 1'b0);
            push_rsp(1'b0, 32'h30000000 + 32'(i));
            rd_q.push_back(32'h30000000 + 32'(i));
        end
        if_req = 1'b1; if_addr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            wait_rdy(1'b0, 32'h80 + 32'(4 * i), 1'b0, 32'h0, 1'b0, reqc);
            rc[i] = cyc;
            advance();
            if_addr = if_addr + 32'd4;
            if (i == 2) if_req = 1'b0;
        end
        chk("t6_gap_0_1", 32'(rc[1] - rc[0]), 32'd3);
        chk("t6_gap_1_2", 32'(rc[2] - rc[1]), 32'd3);

        repeat (5) @(negedge clk);
        chk("end_issue_q_empty", 32'(iss_q.size()), 32'd0);
        chk("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("end_mem_req_idle", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
